cos_accel_seq: RTL and testbench
================================

Name: cos_accel_seq

Overview:
- Multi-cycle sequencer that sits between the Nios II custom-instruction port and the iterative cosine datapath (float-to-fixed conversion, CORDIC iterations, fixed-to-float conversion).
- Accepts a float angle on start, then drives the datapath through its phases: load, N iteration steps, conversion wait.
- Captures the float result and returns it with a single-cycle done pulse.
- Owns the datapath exclusively; holds no arithmetic of its own, except a NaN/Inf bypass.

Parameters:
N_ITER, 16, number of CORDIC iteration steps; must be >= 1.
ITER_W, 5, width of the iteration index; must satisfy 2^ITER_W > N_ITER.
CONV_LAT, 2, cycles the fixed-to-float stage needs after the last step; 0 allowed.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  custom-instruction clock enable; all state frozen while low
start  in  1  one-cycle request, sampled only when clk_en=1
dataa  in  32  IEEE-754 single-precision angle, sampled with start
done  out  1  one-cycle completion pulse
result  out  32  float result; valid while done=1, held afterwards
busy  out  1  high from the cycle after start is accepted until done
dp_x_ft  out  32  registered angle presented to the datapath
dp_load  out  1  datapath input-conversion load strobe
dp_step  out  1  iteration enable
dp_iter  out  ITER_W  current iteration index
dp_final  out  1  high during the conversion-wait cycles
dp_y_ft  in  32  datapath float output, valid by the end of the last CONV cycle

Behaviour:
- Reset (asynchronous):
  - State returns to IDLE.
  - done, busy, dp_load, dp_step and dp_final go to 0.
  - dp_iter, dp_x_ft and result go to 0.
  - Asserting reset mid-operation abandons the operation with no done pulse.
- clk_en=0: no state, counter, or output register updates; all outputs hold their values (including done).
- States: IDLE, LOAD, ITER, CONV, DONE.
  - All outputs are registered (Moore), decoded from state.
- IDLE:
  - start=1 on edge T: latch dataa into dp_x_ft.
  - If dataa[30:23]==8'hFF (NaN or Inf): go to DONE with result <= 32'h7FC00000.
  - Otherwise go to LOAD.
- LOAD (cycle T+1): dp_load=1, busy=1; next state ITER; dp_iter <= 0.
- ITER (cycles T+2 .. T+1+N_ITER): dp_step=1; dp_iter counts 0..N_ITER-1.
  - After index N_ITER-1: go to CONV if CONV_LAT>0; else capture result <= dp_y_ft and go to DONE.
  - dp_iter holds its last value (N_ITER-1) outside ITER.
- CONV (CONV_LAT cycles): dp_final=1.
  - On the edge ending the last CONV cycle: result <= dp_y_ft, go to DONE.
- DONE: done=1 and busy=0 for exactly one (enabled) cycle, then IDLE.
  - start sampled in DONE is accepted exactly as in IDLE, giving back-to-back operations with no idle gap.
- Latency (start accepted at edge T, normal path): done high in cycle T+2+N_ITER+CONV_LAT, i.e. 20 cycles with defaults.
- Latency (NaN/Inf bypass): done high in cycle T+1.
- start while busy=1 (LOAD/ITER/CONV): ignored; dp_x_ft is not overwritten.
- dp_load, dp_step and dp_final are mutually exclusive; at most one is high in any cycle.
- result holds its value until the next capture; it is never cleared by done falling.

Test Plan:
- Reset, then idle 5 cycles -> done=busy=0, result=0, dp_x_ft=0, no datapath strobe asserted.
- Stub datapath drives dp_y_ft=32'h3F3B4F1A; start with dataa=32'h3F400000 (0.75) at edge T -> dp_load at T+1; dp_step T+2..T+17 with dp_iter 0..15; dp_final T+18..T+19; done=1 only at T+20 with result=32'h3F3B4F1A; dp_x_ft=32'h3F400000 throughout.
- dataa=32'h7F800000 (Inf) -> no dp_load/dp_step; done at T+1 with result=32'h7FC00000.
- Second start asserted in the DONE cycle with dataa=32'hBF400000 -> accepted; dp_load in the next cycle; second done exactly 20 cycles later; start pulses during ITER are ignored (dp_x_ft unchanged).
- clk_en low for 3 cycles mid-ITER at dp_iter=7 -> dp_iter stays 7, strobes held; done arrives 3 cycles later than nominal with the correct result.
- reset asserted during CONV -> outputs immediately return to reset values, no done pulse; a following start completes normally.
- CONV_LAT=0, N_ITER=4 build -> done at T+6, result captured from dp_y_ft on the last ITER edge.

Source files
------------

// File: rtl/cos_accel_seq.sv
// cos_accel_seq: sequences the iterative cosine datapath for a custom instruction.
// NaN/Inf angles skip the datapath and return a quiet NaN one cycle after start.
module cos_accel_seq #(
    parameter int N_ITER   = 16,
    parameter int ITER_W   = 5,
    parameter int CONV_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [31:0]       dataa,
    output logic              done,
    output logic [31:0]       result,
    output logic              busy,
    output logic [31:0]       dp_x_ft,
    output logic              dp_load,
    output logic              dp_step,
    output logic [ITER_W-1:0] dp_iter,
    output logic              dp_final,
    input  logic [31:0]       dp_y_ft
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, CONV, DONE} state_t;
    localparam int CW = CONV_LAT > 1 ? $clog2(CONV_LAT) : 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);
    localparam logic [CW-1:0] LAST_CONV = CW'(CONV_LAT > 0 ? CONV_LAT - 1 : 0);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    state_t state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] x_q, x_d, result_q, result_d;
    logic done_q, done_d, busy_q, busy_d, load_q, load_d, step_q, step_d, final_q, final_d;

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    x_d = dataa;
                    if (&dataa[30:23]) begin
                        state_d  = DONE;
                        result_d = QNAN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = ITER;
                iter_d  = '0;
            end
            ITER: begin
                if (iter_q == LAST_ITER) begin
                    cnt_d = '0;
                    if (CONV_LAT > 0) begin
                        state_d = CONV;
                    end else begin
                        state_d  = DONE;
                        result_d = dp_y_ft;
                    end
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            CONV: begin
                if (cnt_q == LAST_CONV) begin
                    state_d  = DONE;
                    result_d = dp_y_ft;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they line up with the registered state
        done_d  = state_d == DONE;
        busy_d  = state_d == LOAD || state_d == ITER || state_d == CONV;
        load_d  = state_d == LOAD;
        step_d  = state_d == ITER;
        final_d = state_d == CONV;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            step_q   <= 1'b0;
            final_q  <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
            step_q   <= step_d;
            final_q  <= final_d;
        end
    end

    assign done     = done_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign dp_x_ft  = x_q;
    assign dp_load  = load_q;
    assign dp_step  = step_q;
    assign dp_iter  = iter_q;
    assign dp_final = final_q;
endmodule

// File: tb/tb_cos_accel_seq.sv
// tb_cos_accel_seq: directed bench with a cycle-timeline model of the sequencer.
module tb_cos_accel_seq;
    localparam int N = 16;
    localparam int C = 2;

    logic clk = 0, reset = 1, clk_en = 1, start = 0;
    logic [31:0] dataa = 0, dp_y_ft = 0;
    logic done, busy, dp_load, dp_step, dp_final;
    logic [31:0] result, dp_x_ft;
    logic [4:0] dp_iter;

    logic start2 = 0;
    logic [31:0] dataa2 = 0, dp_y_ft2 = 0;
    logic done2, busy2, load2, step2, final2;
    logic [31:0] result2, x2;
    logic [2:0] iter2;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    cos_accel_seq #(.N_ITER(N), .ITER_W(5), .CONV_LAT(C)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
        .done(done), .result(result), .busy(busy), .dp_x_ft(dp_x_ft), .dp_load(dp_load),
        .dp_step(dp_step), .dp_iter(dp_iter), .dp_final(dp_final), .dp_y_ft(dp_y_ft)
    );

    cos_accel_seq #(.N_ITER(4), .ITER_W(3), .CONV_LAT(0)) dut2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start2), .dataa(dataa2),
        .done(done2), .result(result2), .busy(busy2), .dp_x_ft(x2), .dp_load(load2),
        .dp_step(step2), .dp_iter(iter2), .dp_final(final2), .dp_y_ft(dp_y_ft2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Model: an accepted operation is just an age counted in enabled cycles.
    bit m_act = 0, m_byp = 0;
    int m_age = 0, m_lat = 0, m_iter = 0;
    logic [31:0] m_res = 0, m_x = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_byp = 0; m_age = 0; m_lat = 0; m_iter = 0; m_res = 0; m_x = 0;
        end else if (clk_en) begin
            if (m_act && m_age == m_lat) m_act = 0;
            else if (m_act) begin
                m_age++;
                if (m_age == m_lat) m_res = dp_y_ft;
                if (m_age >= 2 && m_age <= N + 1) m_iter = m_age - 2;
            end
            if (!m_act && start) begin
                m_act = 1;
                m_age = 1;
                m_x = dataa;
                m_byp = dataa[30:23] == 8'hFF;
                m_lat = m_byp ? 1 : N + 2 + C;
                if (m_byp) m_res = 32'h7FC00000;
            end
        end
    end

    always @(negedge clk) begin
        bit ph;
        ph = m_act && !m_byp;
        chk("m_done", done, m_act && m_age == m_lat);
        chk("m_busy", busy, m_act && m_age < m_lat);
        chk("m_load", dp_load, ph && m_age == 1);
        chk("m_step", dp_step, ph && m_age >= 2 && m_age <= N + 1);
        chk("m_final", dp_final, ph && m_age >= N + 2 && m_age <= N + 1 + C);
        chk("m_iter", dp_iter, m_iter);
        chk("m_result", result, m_res);
        chk("m_x", dp_x_ft, m_x);
    end

    task automatic run_op(input logic [31:0] data, input bit pre, input int gl_at, input int en_off_at,
                          input bit chain, input logic [31:0] nxt, input bit pin, output int n);
        if (!pre) begin
            @(negedge clk);
            start = 1;
            dataa = data;
        end
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            start = 0;
            n++;
            clk_en = !(en_off_at > 0 && n >= en_off_at && n < en_off_at + 3);
            if (en_off_at > 0 && n == en_off_at + 2) chk("iter_frozen", dp_iter, 7);
            if (pin && n == 1) chk("pin_load", dp_load, 1);
            if (pin && n == 17) chk("pin_iter15", dp_iter, 15);
            if (pin && n == 19) chk("pin_final", dp_final, 1);
            if (n == gl_at) begin
                start = 1;
                dataa = 32'h12345678;
            end
            if (done) break;
        end
        if (n >= 100) chk("timeout", 0, 1);
        if (chain) begin
            start = 1;
            dataa = nxt;
        end
    endtask

    initial begin
        int n, steps, finals;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_x", dp_x_ft, 0);
        chk("rst_strobes", {dp_load, dp_step, dp_final}, 0);

        dp_y_ft = 32'h3F3B4F1A;
        run_op(32'h3F400000, 0, 0, 0, 1, 32'hBF400000, 1, n);
        chk("lat_normal", n, 20);
        chk("res_normal", result, 32'h3F3B4F1A);
        chk("x_normal", dp_x_ft, 32'h3F400000);

        dp_y_ft = 32'h3F000001;
        run_op(32'hBF400000, 1, 5, 0, 0, 0, 0, n);
        chk("lat_b2b", n, 20);
        chk("res_b2b", result, 32'h3F000001);
        chk("x_ignored_start", dp_x_ft, 32'hBF400000);
        @(negedge clk);
        chk("done_fell", done, 0);
        chk("result_held", result, 32'h3F000001);

        run_op(32'h7F800000, 0, 0, 0, 0, 0, 0, n);
        chk("lat_inf", n, 1);
        chk("res_inf", result, 32'h7FC00000);
        run_op(32'hFFC12345, 0, 0, 0, 0, 0, 0, n);
        chk("lat_nan", n, 1);

        dp_y_ft = 32'h3F111111;
        run_op(32'h3E800000, 0, 0, 9, 0, 0, 0, n);
        chk("lat_clken", n, 23);
        chk("res_clken", result, 32'h3F111111);

        @(negedge clk);
        start = 1;
        dataa = 32'h3F000000;
        repeat (18) begin
            @(negedge clk);
            start = 0;
        end
        chk("in_conv", dp_final, 1);
        #2 reset = 1;
        @(negedge clk);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_final", dp_final, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_x", dp_x_ft, 0);
        reset = 0;
        dp_y_ft = 32'h3F222222;
        run_op(32'h3F000000, 0, 0, 0, 0, 0, 0, n);
        chk("lat_after_rst", n, 20);
        chk("res_after_rst", result, 32'h3F222222);

        @(negedge clk);
        start2 = 1;
        dataa2 = 32'h3F000000;
        dp_y_ft2 = 32'hAAAA0000;
        n = 0; steps = 0; finals = 0;
        while (n < 100) begin
            @(negedge clk);
            start2 = 0;
            n++;
            if (n == 1) chk("s_load", load2, 1);
            steps += int'(step2);
            finals += int'(final2);
            if (n == 5) dp_y_ft2 = 32'h3F60A8B0;
            if (done2) break;
        end
        chk("s_lat", n, 6);
        chk("s_steps", steps, 4);
        chk("s_finals", finals, 0);
        chk("s_result", result2, 32'h3F60A8B0);
        chk("s_iter_last", iter2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
